// File: rtl/conv_pkg.sv
// conv_pkg: pixel/row-index types and kernel/image defaults shared with image_convolution
package conv_pkg;
  typedef logic [7:0] pixel_t;
  typedef logic [15:0] row_idx_t;
  localparam int HEIGHT_OF_KERNEL = 3;
  localparam int WIDTH_OF_IMAGE = 4;
endpackage

// File: rtl/conv_row_slot_mem.sv
// conv_row_slot_mem: K+1 row slots of W pixels, one pixel write port, K whole-row read ports
module conv_row_slot_mem
  import conv_pkg::*;
#(
  parameter int K = 3,
  parameter int W = 4,
  parameter int SW = $clog2(K + 1),
  parameter int CW = $clog2(W)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [SW-1:0]           wr_slot,
  input  logic [CW-1:0]           wr_col,
  input  pixel_t                  wr_data,
  input  logic [K-1:0][SW-1:0]    rd_slot,
  output logic [K-1:0][W-1:0][7:0] rd_rows
);
  logic [W-1:0][7:0] mem [K+1];
  // pixel storage is not reset; it is only observed through a valid window
  always_ff @(posedge clk)
    if (we) mem[wr_slot][wr_col] <= wr_data;
  for (genvar r = 0; r < K; r++) begin : g_rd
    assign rd_rows[r] = mem[rd_slot[r]];
  end
endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: raster pixel stream in, K vertically adjacent complete rows out per handshake
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int HEIGHT_OF_KERNEL = conv_pkg::HEIGHT_OF_KERNEL,
  parameter int WIDTH_OF_IMAGE = conv_pkg::WIDTH_OF_IMAGE
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  pixel_t in_data,
  input  logic in_sof,
  output logic out_valid,
  input  logic out_ready,
  output logic [HEIGHT_OF_KERNEL-1:0][WIDTH_OF_IMAGE-1:0][7:0] out_rows,
  output row_idx_t out_row_idx,
  output logic sof_err
);
  localparam int K = HEIGHT_OF_KERNEL;
  localparam int W = WIDTH_OF_IMAGE;
  localparam int SW = $clog2(K + 1);
  localparam int CW = $clog2(W);
  logic [CW-1:0] col, ecol;
  logic [SW-1:0] wr_slot, win_base, rows_filled, rf_base, rf_next, slot_next, base_next;
  logic [K-1:0][SW-1:0] rd_slot;
  row_idx_t row_cnt, rc_base;
  logic accept, last, emit;
  assign in_ready = !(out_valid && !out_ready && col == CW'(W - 1));
  assign accept = in_valid && in_ready;
  assign ecol = in_sof ? '0 : col;
  assign last = ecol == CW'(W - 1);
  assign rf_base = in_sof ? '0 : rows_filled;
  assign rc_base = in_sof ? '0 : row_cnt;
  assign rf_next = rf_base == SW'(K) ? rf_base : rf_base + SW'(1);
  assign slot_next = wr_slot == SW'(K) ? '0 : wr_slot + SW'(1);
  assign base_next = wr_slot >= SW'(K - 1) ? wr_slot - SW'(K - 1) : wr_slot + SW'(2);
  assign emit = accept && last && rf_next >= SW'(K);
  for (genvar k = 0; k < K; k++) begin : g_slot
    logic [SW:0] s;
    assign s = {1'b0, win_base} + (SW + 1)'(k);
    assign rd_slot[k] = s > (SW + 1)'(K) ? SW'(s - (SW + 1)'(K + 1)) : SW'(s);
  end
  conv_row_slot_mem #(.K(K), .W(W)) u_mem (
    .clk(clk),
    .we(accept),
    .wr_slot(wr_slot),
    .wr_col(ecol),
    .wr_data(in_data),
    .rd_slot(rd_slot),
    .rd_rows(out_rows)
  );
  // write-side counters, window capture and the sticky frame-alignment error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      wr_slot <= '0;
      rows_filled <= '0;
      row_cnt <= '0;
      win_base <= '0;
      out_valid <= 1'b0;
      out_row_idx <= '0;
      sof_err <= 1'b0;
    end else begin
      if (accept) begin
        col <= last ? '0 : ecol + CW'(1);
        wr_slot <= last ? slot_next : wr_slot;
        rows_filled <= last ? rf_next : rf_base;
        row_cnt <= last ? rc_base + 16'd1 : rc_base;
      end
      if (emit) begin
        win_base <= base_next;
        out_row_idx <= rc_base - row_idx_t'(K / 2);
      end
      out_valid <= emit || (out_valid && !out_ready);
      if (accept && in_sof && col != '0) sof_err <= 1'b1;
    end
endmodule

// File: tb/tb_conv_line_buffer.sv
// tb_conv_line_buffer: directed vector table for K=3,W=4 plus a K=1,W=2 random-stall scoreboard
module tb_conv_line_buffer;
  typedef struct {
    bit v;
    logic [7:0] d;
    bit sof;
    bit rdy;
    bit e_ir;
    bit e_ov;
    int e_idx;
    bit e_err;
    int off;
  } vec_t;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_sof = 0, out_ready = 0, in_ready, out_valid, sof_err;
  logic [7:0] in_data = 0;
  logic [2:0][3:0][7:0] out_rows;
  logic [15:0] out_row_idx;
  logic in_valid2 = 0, in_sof2 = 0, out_ready2 = 0, in_ready2, out_valid2, sof_err2;
  logic [7:0] in_data2 = 0;
  logic [0:0][1:0][7:0] out_rows2;
  logic [15:0] out_row_idx2;
  int errors = 0, checks = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  conv_line_buffer #(.HEIGHT_OF_KERNEL(3), .WIDTH_OF_IMAGE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .out_rows(out_rows),
    .out_row_idx(out_row_idx), .sof_err(sof_err)
  );

  conv_line_buffer #(.HEIGHT_OF_KERNEL(1), .WIDTH_OF_IMAGE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .in_sof(in_sof2), .out_valid(out_valid2), .out_ready(out_ready2), .out_rows(out_rows2),
    .out_row_idx(out_row_idx2), .sof_err(sof_err2)
  );

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(bit v, int d, bit sof, bit rdy, bit e_ir, bit e_ov, int e_idx, bit e_err, int off);
    vec_t x;
    x.v = v; x.d = 8'(d); x.sof = sof; x.rdy = rdy; x.e_ir = e_ir;
    x.e_ov = e_ov; x.e_idx = e_idx; x.e_err = e_err; x.off = off;
    q.push_back(x);
  endtask

  task automatic run_vecs();
    logic [2:0][3:0][7:0] ew;
    foreach (q[i]) begin
      @(negedge clk);
      in_valid = q[i].v; in_data = q[i].d; in_sof = q[i].sof; out_ready = q[i].rdy;
      #1;
      chk($sformatf("in_ready[%0d]", i), 96'(in_ready), 96'(q[i].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("out_valid[%0d]", i), 96'(out_valid), 96'(q[i].e_ov));
      chk($sformatf("sof_err[%0d]", i), 96'(sof_err), 96'(q[i].e_err));
      if (q[i].e_ov) begin
        for (int k = 0; k < 3; k++)
          for (int c = 0; c < 4; c++)
            ew[k][c] = 8'(q[i].off + 16 * (q[i].e_idx - 1 + k) + c);
        chk($sformatf("row_idx[%0d]", i), 96'(out_row_idx), 96'(q[i].e_idx));
        chk($sformatf("window[%0d]", i), 96'(out_rows), 96'(ew));
      end
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; in_sof = 0; out_ready = 0; in_valid2 = 0; in_sof2 = 0; out_ready2 = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int pix, n;
    do_reset();
    #1;
    chk("rst out_valid", 96'(out_valid), 96'(0));
    chk("rst row_idx", 96'(out_row_idx), 96'(0));
    chk("rst sof_err", 96'(sof_err), 96'(0));
    chk("rst in_ready", 96'(in_ready), 96'(1));

    // basic streaming: 5 rows, consumer always ready
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        add(1, 16 * r + c, r == 0 && c == 0, 1, 1, c == 3 && r >= 2, r - 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    run_vecs();

    // back-pressure, then completing pixel accepted on the window handshake edge
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        add(1, 16 * r + c, r == 0 && c == 0, 1, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) add(1, 32 + c, 0, 1, 1, 0, 0, 0, 0);
    add(1, 35, 0, 0, 1, 1, 1, 0, 0);
    for (int c = 0; c < 3; c++) add(1, 48 + c, 0, 0, 1, 1, 1, 0, 0);
    add(1, 51, 0, 0, 0, 1, 1, 0, 0);
    add(1, 51, 0, 0, 0, 1, 1, 0, 0);
    add(1, 51, 0, 1, 1, 1, 2, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    run_vecs();

    // misplaced sof restarts the frame and sets the sticky error
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        add(1, 16 * r + c, r == 0 && c == 0, 1, 1, c == 3 && r == 2, 1, 0, 0);
    add(1, 48, 0, 1, 1, 0, 0, 0, 0);
    add(1, 49, 0, 1, 1, 0, 0, 0, 0);
    add(1, 128, 1, 1, 1, 0, 0, 1, 0);
    for (int r = 0; r < 3; r++)
      for (int c = (r == 0) ? 1 : 0; c < 4; c++)
        add(1, 128 + 16 * r + c, 0, r < 2, 1, c == 3 && r == 2, 1, 1, 128);
    add(1, 176, 0, 0, 1, 1, 1, 1, 128);
    add(1, 177, 0, 0, 1, 1, 1, 1, 128);
    run_vecs();

    // asynchronous reset mid-row with a window held
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("async out_valid", 96'(out_valid), 96'(0));
    chk("async sof_err", 96'(sof_err), 96'(0));
    chk("async row_idx", 96'(out_row_idx), 96'(0));
    @(negedge clk);
    rst = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        add(1, 64 + 16 * r + c, r == 0 && c == 0, 1, 1, c == 3 && r == 2, 1, 0, 64);
    run_vecs();

    // K=1, W=2: one-cycle latency, then random stalls against a row scoreboard
    do_reset();
    @(negedge clk);
    in_valid2 = 1; in_data2 = 0; in_sof2 = 1; out_ready2 = 0;
    @(negedge clk);
    in_data2 = 1; in_sof2 = 0;
    @(posedge clk);
    #1;
    chk("k1 latency out_valid", 96'(out_valid2), 96'(1));
    chk("k1 first row_idx", 96'(out_row_idx2), 96'(0));
    pix = 2;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid2 = i < 500 && $urandom_range(3) != 0;
      out_ready2 = i >= 500 || $urandom_range(2) != 0;
      in_data2 = 8'(pix);
      #1;
      if (out_valid2 && out_ready2) begin
        chk($sformatf("k1 row %0d data", n), 96'(out_rows2), 96'({8'(2 * n + 1), 8'(2 * n)}));
        chk($sformatf("k1 row %0d idx", n), 96'(out_row_idx2), 96'(n));
        n++;
      end
      if (in_valid2 && in_ready2) pix++;
    end
    chk("k1 rows delivered", 96'(n), 96'(pix / 2));
    chk("k1 sof_err", 96'(sof_err2), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
